// File: rtl/ram_pkg.sv
// Shared types and default constants for the banked RAM controller.
package ram_pkg;

   localparam int DEF_BANK_GRPS     = 2;
   localparam int DEF_BANKS_PER_GRP = 4;
   localparam int DEF_ROW_W         = 3;
   localparam int DEF_COL_W         = 3;
   localparam int DEF_DATA_W        = 16;
   localparam int DEF_T_RCD         = 2;
   localparam int DEF_T_RP          = 2;
   localparam int CNT_W             = 8;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ACT,
      RCD_WAIT,
      BURST,
      APRE
   } state_t;

   typedef struct packed {
      logic       rwb;
      logic       auto_pre;
      logic [2:0] burst_len;
   } req_ctrl_t;

   // Index width that never collapses to zero bits for single-entry dimensions.
   function automatic int min1_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_bank_table.sv
// Per-bank open flag and open-row bookkeeping, addressed by flat bank index.
module ram_bank_table import ram_pkg::*; #(
   parameter int NB    = 8,
   parameter int ROW_W = 3,
   parameter int IDX_W = min1_clog2(NB)
) (
   input  logic             clk_t,
   input  logic             reset_n,
   input  logic             set,
   input  logic             clr,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic [ROW_W-1:0] upd_row,
   input  logic [IDX_W-1:0] lookup_idx,
   output logic             lookup_open,
   output logic [ROW_W-1:0] lookup_row,
   output logic [NB-1:0]    open_flags
);

   logic [ROW_W-1:0] rows [NB];

   always_ff @(posedge clk_t or negedge reset_n) begin
      if (!reset_n) begin
         open_flags <= '0;
         for (int i = 0; i < NB; i++) begin
            rows[i] <= '0;
         end
      end else if (set) begin
         open_flags[upd_idx] <= 1'b1;
         rows[upd_idx]       <= upd_row;
      end else if (clr) begin
         open_flags[upd_idx] <= 1'b0;
      end
   end

   assign lookup_open = open_flags[lookup_idx];
   assign lookup_row  = rows[lookup_idx];

endmodule

// File: rtl/ram_bank_ctrl.sv
// Banked RAM controller: row open/precharge sequencing with burst reads and writes.
module ram_bank_ctrl import ram_pkg::*; #(
   parameter int BANK_GRPS     = DEF_BANK_GRPS,
   parameter int BANKS_PER_GRP = DEF_BANKS_PER_GRP,
   parameter int ROW_W         = DEF_ROW_W,
   parameter int COL_W         = DEF_COL_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int T_RCD         = DEF_T_RCD,
   parameter int T_RP          = DEF_T_RP,
   localparam int BG_W         = min1_clog2(BANK_GRPS),
   localparam int BANK_W       = min1_clog2(BANKS_PER_GRP)
) (
   input  logic                           clk_t,
   input  logic                           reset_n,
   input  logic                           cke,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_rwb,
   input  logic                           req_auto_pre,
   input  logic [BG_W-1:0]                req_bank_grp,
   input  logic [BANK_W-1:0]              req_bank,
   input  logic [ROW_W-1:0]               req_row,
   input  logic [COL_W-1:0]               req_col,
   input  logic [2:0]                     req_burst_len,
   input  logic [DATA_W-1:0]              wr_data,
   output logic                           wr_data_ready,
   output logic [DATA_W-1:0]              rd_data,
   output logic                           rd_valid,
   output logic [BANK_GRPS*BANKS_PER_GRP-1:0] bank_open,
   output logic                           busy
);

   localparam int NB     = BANK_GRPS * BANKS_PER_GRP;
   localparam int IDX_W  = min1_clog2(NB);
   localparam int ADDR_W = IDX_W + ROW_W + COL_W;
   localparam int DEPTH  = NB << (ROW_W + COL_W);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       beat_idx, beat_idx_n;
   logic [COL_W-1:0] col, col_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [ROW_W-1:0] row, row_n;
   req_ctrl_t        ctrl, ctrl_n;

   logic [IDX_W-1:0] req_idx;
   logic             lk_open;
   logic [ROW_W-1:0] lk_row;
   logic             tbl_set, tbl_clr;
   logic             accept, beat, rd_valid_q;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] mem [DEPTH];

   assign req_idx       = IDX_W'(req_bank_grp) * IDX_W'(BANKS_PER_GRP) + IDX_W'(req_bank);
   assign req_ready     = reset_n & cke & (state == IDLE);
   assign accept        = req_valid & req_ready;
   assign beat          = cke & (state == BURST);
   assign wr_data_ready = beat & ~ctrl.rwb;
   assign busy          = (state != IDLE);
   assign addr          = {idx, row, col};
   // Held read beats stay invisible while the clock is gated and reappear on resume.
   assign rd_valid      = rd_valid_q & cke;

   ram_bank_table #(
      .NB    (NB),
      .ROW_W (ROW_W),
      .IDX_W (IDX_W)
   ) u_table (
      .clk_t       (clk_t),
      .reset_n     (reset_n),
      .set         (tbl_set & cke),
      .clr         (tbl_clr & cke),
      .upd_idx     (idx),
      .upd_row     (row),
      .lookup_idx  (req_idx),
      .lookup_open (lk_open),
      .lookup_row  (lk_row),
      .open_flags  (bank_open)
   );

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      beat_idx_n = beat_idx;
      col_n      = col;
      idx_n      = idx;
      row_n      = row;
      ctrl_n     = ctrl;
      tbl_set    = 1'b0;
      tbl_clr    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               idx_n      = req_idx;
               row_n      = req_row;
               col_n      = req_col;
               beat_idx_n = '0;
               ctrl_n     = '{rwb: req_rwb, auto_pre: req_auto_pre, burst_len: req_burst_len};
               if (lk_open && (lk_row == req_row)) begin
                  state_n = BURST;
               end else if (lk_open) begin
                  state_n = PRE;
                  cnt_n   = CNT_W'(T_RP - 1);
               end else begin
                  state_n = ACT;
               end
            end
         end
         PRE: begin
            if (cnt == '0) begin
               tbl_clr = 1'b1;
               state_n = ACT;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         ACT: begin
            tbl_set = 1'b1;
            if (T_RCD <= 1) begin
               state_n = BURST;
            end else begin
               state_n = RCD_WAIT;
               cnt_n   = CNT_W'(T_RCD - 2);
            end
         end
         RCD_WAIT: begin
            if (cnt == '0) begin
               state_n = BURST;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         BURST: begin
            col_n = col + COL_W'(1);
            if (beat_idx == ctrl.burst_len) begin
               if (ctrl.auto_pre) begin
                  state_n = APRE;
                  cnt_n   = CNT_W'(T_RP - 1);
               end else begin
                  state_n = IDLE;
               end
            end else begin
               beat_idx_n = beat_idx + 3'd1;
            end
         end
         APRE: begin
            if (cnt == '0) begin
               tbl_clr = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_t or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         beat_idx <= '0;
         col      <= '0;
         idx      <= '0;
         row      <= '0;
         ctrl     <= '0;
      end else if (cke) begin
         state    <= state_n;
         cnt      <= cnt_n;
         beat_idx <= beat_idx_n;
         col      <= col_n;
         idx      <= idx_n;
         row      <= row_n;
         ctrl     <= ctrl_n;
      end
   end

   // Storage is deliberately left out of reset so data survives an aborted burst.
   always_ff @(posedge clk_t) begin
      if (wr_data_ready) begin
         mem[addr] <= wr_data;
      end
   end

   always_ff @(posedge clk_t or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_data    <= '0;
      end else if (cke) begin
         rd_valid_q <= beat & ctrl.rwb;
         if (beat && ctrl.rwb) begin
            rd_data <= mem[addr];
         end
      end
   end

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// Directed vector bench for ram_bank_ctrl: latency, data, bank flags, cke stall and reset abort.
module tb_ram_bank_ctrl;

   logic        clk_t;
   logic        reset_n;
   logic        cke;
   logic        req_valid;
   logic        req_ready;
   logic        req_rwb;
   logic        req_auto_pre;
   logic [0:0]  req_bank_grp;
   logic [1:0]  req_bank;
   logic [2:0]  req_row;
   logic [2:0]  req_col;
   logic [2:0]  req_burst_len;
   logic [15:0] wr_data;
   logic        wr_data_ready;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [7:0]  bank_open;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic        rwb;
      logic        ap;
      logic [0:0]  grp;
      logic [1:0]  bank;
      logic [2:0]  row;
      logic [2:0]  col;
      logic [2:0]  len;
      logic [15:0] base;
      int          lat;
      logic [7:0]  open_after;
   } vec_t;

   vec_t        vecs [13];
   logic [15:0] model [512];
   bit          written [512];

   ram_bank_ctrl dut (
      .clk_t         (clk_t),
      .reset_n       (reset_n),
      .cke           (cke),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_rwb       (req_rwb),
      .req_auto_pre  (req_auto_pre),
      .req_bank_grp  (req_bank_grp),
      .req_bank      (req_bank),
      .req_row       (req_row),
      .req_col       (req_col),
      .req_burst_len (req_burst_len),
      .wr_data       (wr_data),
      .wr_data_ready (wr_data_ready),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .bank_open     (bank_open),
      .busy          (busy)
   );

   always #5 clk_t = ~clk_t;

   always @(posedge clk_t) cyc <= cyc + 1;

   function automatic int maddr(input int bidx, input int r, input int c);
      return bidx * 64 + r * 8 + (c & 7);
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic wait_ready();
      int g = 0;
      @(negedge clk_t);
      #1;
      while (!req_ready && g < 50) begin
         @(negedge clk_t);
         #1;
         g++;
      end
   endtask

   task automatic drive_req(input logic rwb, input logic ap, input logic [0:0] grp, input logic [1:0] bank,
                            input logic [2:0] r, input logic [2:0] c, input logic [2:0] len);
      req_rwb       = rwb;
      req_auto_pre  = ap;
      req_bank_grp  = grp;
      req_bank      = bank;
      req_row       = r;
      req_col       = c;
      req_burst_len = len;
      req_valid     = 1'b1;
   endtask

   task automatic apply_stimulus(input int v);
      vec_t t;
      int bidx, n, got, first, last, nb, a, g;
      t     = vecs[v];
      bidx  = int'(t.grp) * 4 + int'(t.bank);
      nb    = int'(t.len) + 1;
      got   = 0;
      first = -1;
      last  = 0;
      wait_ready();
      check_output($sformatf("v%0d_ready", v), {31'd0, req_ready}, 32'd1);
      drive_req(t.rwb, t.ap, t.grp, t.bank, t.row, t.col, t.len);
      n = cyc;
      for (int k = 0; k < 40 && got < nb; k++) begin
         @(negedge clk_t);
         req_valid = 1'b0;
         #1;
         if (!t.rwb && wr_data_ready) begin
            a          = maddr(bidx, int'(t.row), int'(t.col) + got);
            wr_data    = t.base + 16'(got);
            model[a]   = wr_data;
            written[a] = 1'b1;
            if (first < 0) first = cyc - n;
            last = cyc;
            got++;
         end else if (t.rwb && rd_valid) begin
            a = maddr(bidx, int'(t.row), int'(t.col) + got);
            if (written[a]) check_output($sformatf("v%0d_data%0d", v, got), {16'd0, rd_data}, {16'd0, model[a]});
            if (first < 0) first = cyc - n;
            last = cyc - 1;
            got++;
         end
      end
      check_output($sformatf("v%0d_latency", v), first, t.lat);
      check_output($sformatf("v%0d_beats", v), got, nb);
      g = 0;
      while (busy && g < 20) begin
         @(negedge clk_t);
         #1;
         g++;
      end
      check_output($sformatf("v%0d_tail", v), cyc - last - 1, t.ap ? 2 : 0);
      check_output($sformatf("v%0d_idle_ready", v), {31'd0, req_ready}, 32'd1);
      check_output($sformatf("v%0d_bank_open", v), {24'd0, bank_open}, {24'd0, t.open_after});
   endtask

   task automatic cke_pause_seq();
      int n, got, pause, a;
      got   = 0;
      pause = 0;
      @(negedge clk_t);
      cke = 1'b0;
      #1;
      check_output("cke_low_ready", {31'd0, req_ready}, 32'd0);
      cke = 1'b1;
      #1;
      check_output("cke_high_ready", {31'd0, req_ready}, 32'd1);
      drive_req(1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 3'd2, 3'd3);
      n = cyc;
      for (int k = 0; k < 40 && got < 4; k++) begin
         @(negedge clk_t);
         req_valid = 1'b0;
         if (got == 2 && pause < 3) begin
            cke = 1'b0;
            pause++;
         end else begin
            cke = 1'b1;
         end
         #1;
         if (!cke) begin
            check_output("cke_rd_valid", {31'd0, rd_valid}, 32'd0);
            check_output("cke_busy", {31'd0, busy}, 32'd1);
         end else if (rd_valid) begin
            a = maddr(1, 3, 2 + got);
            check_output($sformatf("cke_data%0d", got), {16'd0, rd_data}, {16'd0, model[a]});
            got++;
            if (got == 3) check_output("cke_resume_cycle", cyc - n, 7);
            if (got == 4) check_output("cke_last_cycle", cyc - n, 8);
         end
      end
      cke = 1'b1;
      check_output("cke_beats", got, 4);
   endtask

   task automatic reset_mid_burst_seq();
      int n, got, a, first;
      bit done;
      got   = 0;
      first = -1;
      done  = 1'b0;
      wait_ready();
      drive_req(1'b0, 1'b0, 1'b0, 2'd3, 3'd1, 3'd0, 3'd7);
      n = cyc;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk_t);
         req_valid = 1'b0;
         #1;
         if (wr_data_ready) begin
            if (got < 2) begin
               if (first < 0) first = cyc - n;
               a          = maddr(3, 1, got);
               wr_data    = 16'h00E0 + 16'(got);
               model[a]   = wr_data;
               written[a] = 1'b1;
               got++;
            end else begin
               reset_n = 1'b0;
               #1;
               done = 1'b1;
            end
         end
      end
      check_output("rst_reached", {31'd0, done}, 32'd1);
      check_output("rst_wr_latency", first, 3);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_bank_open", {24'd0, bank_open}, 32'd0);
      check_output("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check_output("rst_wr_ready", {31'd0, wr_data_ready}, 32'd0);
      check_output("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check_output("rst_rd_data", {16'd0, rd_data}, 32'd0);
      @(negedge clk_t);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clk_t         = 1'b0;
      reset_n       = 1'b1;
      cke           = 1'b1;
      req_valid     = 1'b0;
      req_rwb       = 1'b0;
      req_auto_pre  = 1'b0;
      req_bank_grp  = '0;
      req_bank      = '0;
      req_row       = '0;
      req_col       = '0;
      req_burst_len = '0;
      wr_data       = '0;
      for (int i = 0; i < 512; i++) written[i] = 1'b0;

      //            rwb   ap    grp   bank  row   col   len   base      lat open_after
      vecs[0]  = '{1'b0, 1'b0, 1'd0, 2'd1, 3'd3, 3'd2, 3'd3, 16'h00A0, 3, 8'h02};
      vecs[1]  = '{1'b1, 1'b0, 1'd0, 2'd1, 3'd3, 3'd2, 3'd3, 16'h0000, 2, 8'h02};
      vecs[2]  = '{1'b0, 1'b0, 1'd0, 2'd1, 3'd5, 3'd0, 3'd1, 16'h00B0, 5, 8'h02};
      vecs[3]  = '{1'b1, 1'b0, 1'd0, 2'd1, 3'd5, 3'd0, 3'd1, 16'h0000, 2, 8'h02};
      vecs[4]  = '{1'b1, 1'b0, 1'd0, 2'd1, 3'd3, 3'd2, 3'd3, 16'h0000, 6, 8'h02};
      vecs[5]  = '{1'b0, 1'b0, 1'd1, 2'd2, 3'd0, 3'd6, 3'd3, 16'h00C0, 3, 8'h42};
      vecs[6]  = '{1'b1, 1'b0, 1'd1, 2'd2, 3'd0, 3'd0, 3'd1, 16'h0000, 2, 8'h42};
      vecs[7]  = '{1'b1, 1'b1, 1'd1, 2'd2, 3'd0, 3'd6, 3'd3, 16'h0000, 2, 8'h02};
      vecs[8]  = '{1'b1, 1'b0, 1'd1, 2'd2, 3'd0, 3'd7, 3'd0, 16'h0000, 4, 8'h42};
      vecs[9]  = '{1'b0, 1'b1, 1'd0, 2'd0, 3'd7, 3'd7, 3'd7, 16'h00D0, 3, 8'h42};
      vecs[10] = '{1'b1, 1'b0, 1'd0, 2'd0, 3'd7, 3'd0, 3'd7, 16'h0000, 4, 8'h43};
      vecs[11] = '{1'b1, 1'b0, 1'd0, 2'd3, 3'd1, 3'd0, 3'd1, 16'h0000, 4, 8'h08};
      vecs[12] = '{1'b1, 1'b0, 1'd0, 2'd1, 3'd3, 3'd2, 3'd0, 16'h0000, 4, 8'h0A};

      #2;
      reset_n = 1'b0;
      @(negedge clk_t);
      @(negedge clk_t);
      #1;
      check_output("reset_req_ready", {31'd0, req_ready}, 32'd0);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      check_output("reset_bank_open", {24'd0, bank_open}, 32'd0);
      check_output("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      check_output("reset_wr_ready", {31'd0, wr_data_ready}, 32'd0);
      check_output("reset_rd_data", {16'd0, rd_data}, 32'd0);
      @(negedge clk_t);
      reset_n = 1'b1;

      for (int v = 0; v <= 10; v++) apply_stimulus(v);
      cke_pause_seq();
      reset_mid_burst_seq();
      for (int v = 11; v <= 12; v++) apply_stimulus(v);

      repeat (2) @(negedge clk_t);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_bank_ctrl.md
RAM_BANK_CTRL -- requirements
Module: ram_bank_ctrl

Interface
REQ-001 Parameter BANK_GRPS, default 2, number of bank groups (BG_W = clog2, min 1).
REQ-002 Parameter BANKS_PER_GRP, default 4, banks per group (BANK_W = clog2).
REQ-003 Parameter ROW_W, default 3; COL_W, default 3; DATA_W, default 16.
REQ-004 Parameter T_RCD, default 2, ACT-to-first-beat cycles (>=1); T_RP, default 2, precharge cycles (>=1).
REQ-005 clk_t  in  1  sole clock, all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cke  in  1  clock enable; low freezes the block.
REQ-008 req_valid  in  1 / req_ready  out  1  request handshake.
REQ-009 req_rwb  in  1  1=read, 0=write; req_auto_pre  in  1  precharge after burst.
REQ-010 req_bank_grp  in  BG_W / req_bank  in  BANK_W / req_row  in  ROW_W / req_col  in  COL_W  target.
REQ-011 req_burst_len  in  3  beats = value+1 (1..8).
REQ-012 wr_data  in  DATA_W / wr_data_ready  out  1  write beat consumed this cycle.
REQ-013 rd_data  out  DATA_W / rd_valid  out  1  read beat.
REQ-014 bank_open  out  BANK_GRPS*BANKS_PER_GRP  per-bank open flag, index {grp,bank}; busy  out  1  state != IDLE.

Function
REQ-015 Storage SHALL be NB x 2^ROW_W x 2^COL_W words of DATA_W (NB = BANK_GRPS*BANKS_PER_GRP), never reset.
REQ-016 FSM states SHALL be IDLE, PRE, ACT, RCD_WAIT, BURST, APRE.
REQ-017 req_ready SHALL be 1 only in IDLE with cke=1; accept on req_valid&req_ready latches all req_* fields.
REQ-018 On accept: bank open, same row -> BURST (hit); open, other row -> PRE (conflict); closed -> ACT.
REQ-019 PRE SHALL last T_RP cycles, clear the bank's open flag, then -> ACT.
REQ-020 ACT SHALL last 1 cycle, set open flag and open row; then RCD_WAIT for T_RCD-1 cycles (skipped if T_RCD=1) -> BURST.
REQ-021 BURST SHALL run burst_len+1 beats, one per cycle; column increments modulo 2^COL_W (wraps, row unchanged).
REQ-022 Write beat: wr_data_ready=1 that cycle, wr_data stored at current address.
REQ-023 Read beat: rd_data/rd_valid registered, valid the cycle after the beat; rd_valid=0 otherwise.
REQ-024 After last beat: req_auto_pre=1 -> APRE (T_RP cycles, clears open flag) -> IDLE; else -> IDLE, row stays open.
REQ-025 Latency from accept cycle N, read: hit rd_valid at N+2; closed N+1+T_RCD+1; conflict N+T_RP+T_RCD+2.
REQ-026 cke=0: state, counters, tables, memory frozen; no writes; req_ready, wr_data_ready, rd_valid = 0; resumes exactly where stopped.
REQ-027 Back-to-back: request accepted in the IDLE cycle following a burst; no idle bubble beyond that cycle.

Reset
REQ-028 reset_n low SHALL asynchronously force IDLE, counters 0, all banks closed, open-row table 0, all outputs 0.
REQ-029 Reset mid-burst SHALL abort it; already-written words persist, no further writes.

Structure
REQ-030 Package ram_pkg SHALL hold the state enum, request struct typedef and default parameter constants.
REQ-031 Open-flag/open-row tracking SHALL be sub-module ram_bank_table (set, clear, lookup by flat index).

Verification (defaults)
REQ-032 Write grp0/bank1 row3 col2 len=3 data A0..A3, no auto_pre -> ACT N+1, writes N+3..N+6, bank_open[1]=1.
REQ-033 Read same row col2 len=3 -> hit, rd_valid N+2..N+5 data A0..A3.
REQ-034 Read bank1 row5 -> conflict: PRE 2 cycles, ACT, rd_valid first at N+6.
REQ-035 Write col6 len=3 -> wrap to cols 6,7,0,1; readback confirms; auto_pre=1 clears bank_open after 2 cycles.
REQ-036 cke=0 for 3 cycles mid-read -> beats pause, no lost/duplicated data; reset_n low mid-burst -> outputs 0, busy=0, bank_open=0.
